// File: rtl/dca_lsu_row_merge_buffer_pkg.sv
// Shared widths and helpers for the DCA LSU row merge buffer.
// Defaults match the production row geometry.
package dca_lsu_row_merge_buffer_pkg;
    localparam int BW_ROW_DEF  = 128;
    localparam int BW_INFO_DEF = 16;
    localparam int DEPTH_DEF   = 4;

    function automatic int wstrb_w(int bw_row);
        return bw_row / 8;
    endfunction

    function automatic int entry_w(int bw_row, int bw_info);
        return bw_row + bw_row / 8 + bw_info;
    endfunction

    function automatic int cnt_w(int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/dca_lsu_row_merge_buffer_if.sv
// Beat-in / row-out handshake bundle of the row merge buffer.
// master = formatter + W channel side, slave = the buffer.
interface dca_lsu_row_merge_buffer_if
    import dca_lsu_row_merge_buffer_pkg::*;
#(
    parameter int BW_ROW  = BW_ROW_DEF,
    parameter int BW_INFO = BW_INFO_DEF
);
    localparam int BW_STRB = wstrb_w(BW_ROW);

    logic               in_valid;
    logic               in_ready;
    logic [BW_ROW-1:0]  in_data;
    logic [BW_ROW-1:0]  in_bitmask;
    logic               in_commit;
    logic [BW_INFO-1:0] in_info;
    logic               out_valid;
    logic               out_ready;
    logic [BW_ROW-1:0]  out_data;
    logic [BW_STRB-1:0] out_wstrb;
    logic [BW_INFO-1:0] out_info;

    modport master (
        output in_valid, in_data, in_bitmask, in_commit, in_info, out_ready,
        input  in_ready, out_valid, out_data, out_wstrb, out_info
    );

    modport slave (
        input  in_valid, in_data, in_bitmask, in_commit, in_info, out_ready,
        output in_ready, out_valid, out_data, out_wstrb, out_info
    );
endinterface

// File: rtl/dca_lsu_row_merge_buffer_fifo.sv
// Row entry FIFO: storage, wrapping pointers and occupancy count.
// Push on full and pop on empty are ignored; clear empties it.
module dca_lsu_row_merge_buffer_fifo
    import dca_lsu_row_merge_buffer_pkg::*;
#(
    parameter int BW_ENTRY = 176,
    parameter int DEPTH    = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstnn,
    input  logic                      clear,
    input  logic                      push,
    input  logic [BW_ENTRY-1:0]       wdata,
    input  logic                      pop,
    output logic [BW_ENTRY-1:0]       rdata,
    output logic [cnt_w(DEPTH)-1:0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [BW_ENTRY-1:0] mem_q [DEPTH];
    logic [BW_ENTRY-1:0] mem_d [DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                do_push, do_pop;

    always_comb begin
        do_push  = push & (count_q != CW'(DEPTH)) & ~clear;
        do_pop   = pop & (count_q != '0) & ~clear;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/dca_lsu_row_merge_buffer.sv
// Store-side row assembler: merges masked beats, queues committed rows.
// Optional DCA_ROW_MERGE_MASK_CHECK_EN flags partially masked bytes.
module dca_lsu_row_merge_buffer
    import dca_lsu_row_merge_buffer_pkg::*;
#(
    parameter int BW_ROW  = BW_ROW_DEF,
    parameter int BW_INFO = BW_INFO_DEF,
    parameter int DEPTH   = DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rstnn,
    input  logic                      clear,
    input  logic                      enable,
    dca_lsu_row_merge_buffer_if.slave bus,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      mask_error
);
    localparam int BW_STRB  = wstrb_w(BW_ROW);
    localparam int BW_ENTRY = entry_w(BW_ROW, BW_INFO);
    localparam int CW       = cnt_w(DEPTH);

    logic [BW_ROW-1:0]   acc_data_q, acc_data_d;
    logic [BW_STRB-1:0]  acc_strb_q, acc_strb_d;
    logic [BW_ROW-1:0]   merged;
    logic [BW_STRB-1:0]  byte_strb;
    logic [BW_STRB-1:0]  strb_or;
    logic [BW_ENTRY-1:0] wdata, rdata;
    logic                accept, push, pop;
    logic [CW-1:0]       fifo_count;

    assign bus.in_ready  = enable & (fifo_count != CW'(DEPTH));
    assign bus.out_valid = (fifo_count != '0);

    always_comb begin
        accept = bus.in_valid & bus.in_ready & ~clear;
        merged = (~bus.in_bitmask & acc_data_q) | (bus.in_bitmask & bus.in_data);
        for (int i = 0; i < BW_STRB; i++) byte_strb[i] = bus.in_bitmask[8*i];
        strb_or    = acc_strb_q | byte_strb;
        push       = accept & bus.in_commit;
        pop        = bus.out_valid & bus.out_ready & ~clear;
        wdata      = {merged, strb_or, bus.in_info};
        acc_data_d = accept ? merged : acc_data_q;
        acc_strb_d = acc_strb_q;
        if (accept) acc_strb_d = bus.in_commit ? '0 : strb_or;
        if (clear) acc_strb_d = '0;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            acc_data_q <= '0;
            acc_strb_q <= '0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_strb_q <= acc_strb_d;
        end
    end

`ifdef DCA_ROW_MERGE_MASK_CHECK_EN
    logic mask_err_q, mask_err_d;
    logic bad_byte;

    always_comb begin
        bad_byte = 1'b0;
        for (int i = 0; i < BW_STRB; i++) begin
            if (bus.in_bitmask[8*i +: 8] != 8'h00 &&
                bus.in_bitmask[8*i +: 8] != 8'hFF) bad_byte = 1'b1;
        end
        mask_err_d = mask_err_q | (accept & bad_byte);
        if (clear) mask_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) mask_err_q <= 1'b0;
        else        mask_err_q <= mask_err_d;
    end

    assign mask_error = mask_err_q;
`else
    assign mask_error = 1'b0;
`endif

    dca_lsu_row_merge_buffer_fifo #(
        .BW_ENTRY (BW_ENTRY),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstnn (rstnn),
        .clear (clear),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .count (fifo_count)
    );

    // Head fields come straight from storage, so they hold under backpressure.
    assign bus.out_data  = rdata[BW_ENTRY-1 -: BW_ROW];
    assign bus.out_wstrb = rdata[BW_INFO +: BW_STRB];
    assign bus.out_info  = rdata[BW_INFO-1:0];
    assign count         = fifo_count;
endmodule

// File: tb/tb_dca_lsu_row_merge_buffer.sv
// Directed scoreboard bench for dca_lsu_row_merge_buffer (32-bit rows, depth 4).
// Honours DCA_ROW_MERGE_MASK_CHECK_EN when checking mask_error.
module tb_dca_lsu_row_merge_buffer;
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  s;
        logic [15:0] i;
    } row_t;

    logic       clk = 1'b0;
    logic       rstnn;
    logic       clear;
    logic       enable;
    logic [2:0] count;
    logic       mask_error;

    int checks   = 0;
    int failures = 0;

    row_t        sb[$];
    logic [31:0] m_acc;
    logic [3:0]  m_strb;
    logic        exp_err;

    dca_lsu_row_merge_buffer_if #(.BW_ROW(32), .BW_INFO(16)) bus ();

    dca_lsu_row_merge_buffer #(
        .BW_ROW  (32),
        .BW_INFO (16),
        .DEPTH   (4)
    ) u_dut (
        .clk        (clk),
        .rstnn      (rstnn),
        .clear      (clear),
        .enable     (enable),
        .bus        (bus),
        .count      (count),
        .mask_error (mask_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        if (sb.size() != 0) begin
            chk({tag, "_data"}, 64'(bus.out_data), 64'(sb[0].d));
            chk({tag, "_wstrb"}, 64'(bus.out_wstrb), 64'(sb[0].s));
            chk({tag, "_info"}, 64'(bus.out_info), 64'(sb[0].i));
        end else begin
            checks++;
            failures++;
            $error("FAIL %s_scoreboard observed=pop expected=empty", tag);
        end
    endtask

    task automatic model_beat(input logic [31:0] d, input logic [31:0] m,
                              input logic c, input logic [15:0] info);
        logic [3:0] bs;
        logic [31:0] mg;
        for (int k = 0; k < 4; k++) bs[k] = m[8*k];
        mg = (~m & m_acc) | (m & d);
        if (c) sb.push_back('{d: mg, s: m_strb | bs, i: info});
        m_acc  = mg;
        m_strb = c ? 4'b0 : (m_strb | bs);
    endtask

    task automatic beat(input string tag, input logic [31:0] d,
                        input logic [31:0] m, input logic c,
                        input logic [15:0] info, input logic do_pop);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_bitmask = m;
        bus.in_commit  = c;
        bus.in_info    = info;
        bus.out_ready  = do_pop;
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        if (do_pop) begin
            check_head(tag);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        model_beat(d, m, c, info);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_commit = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic pop_one(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        check_head(tag);
        if (sb.size() != 0) void'(sb.pop_front());
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_count(input string tag);
        @(negedge clk);
        chk(tag, 64'(count), 64'(sb.size()));
    endtask

    initial begin
        rstnn          = 1'b0;
        clear          = 1'b0;
        enable         = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_bitmask = '0;
        bus.in_commit  = 1'b0;
        bus.in_info    = '0;
        bus.out_ready  = 1'b0;
        m_acc          = '0;
        m_strb         = '0;
`ifdef DCA_ROW_MERGE_MASK_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_mask_error", 64'(mask_error), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_wstrb", 64'(bus.out_wstrb), 64'd0);
        rstnn  = 1'b1;
        enable = 1'b1;

        // two-beat merge, visible the cycle after commit
        beat("t1b0", 32'h11223344, 32'h0000FFFF, 1'b0, 16'h0001, 1'b0);
        beat("t1b1", 32'hAABBCCDD, 32'hFF000000, 1'b1, 16'h0001, 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data_const", 64'(bus.out_data), 64'hAA003344);
        chk("t1_wstrb_const", 64'(bus.out_wstrb), 64'b1011);
        pop_one("t1_pop");
        check_count("t1_count");

        // pop on empty is ignored
        pop_one_empty();

        // fill under backpressure
        for (int n = 0; n < 4; n++)
            beat("t2_push", 32'hC0DE0000 + 32'(n), 32'hFFFFFFFF, 1'b1,
                 16'(16'h10 + n), 1'b0);
        @(negedge clk);
        chk("t2_full_count", 64'(count), 64'd4);
        chk("t2_full_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        check_head("t2_hold");
        pop_one("t2_pop0");
        @(negedge clk);
        chk("t2_in_ready_back", 64'(bus.in_ready), 64'd1);
        chk("t2_count3", 64'(count), 64'd3);
        for (int n = 0; n < 3; n++) pop_one("t2_drain");
        check_count("t2_empty");

        // simultaneous push and pop at count 2
        beat("t3_p1", 32'h01010101, 32'hFFFF00FF, 1'b1, 16'd1, 1'b0);
        beat("t3_p2", 32'h02020202, 32'h00FFFF00, 1'b1, 16'd2, 1'b0);
        check_count("t3_count2");
        beat("t3_pp", 32'h03030303, 32'hFF0000FF, 1'b1, 16'd3, 1'b1);
        @(negedge clk);
        chk("t3_count_stays", 64'(count), 64'd2);
        pop_one("t3_pop2");
        pop_one("t3_pop3");

        // clear mid-row with three rows queued
        for (int n = 0; n < 3; n++)
            beat("t4_push", 32'h40404040 + 32'(n), 32'hFFFFFFFF, 1'b1,
                 16'(16'h40 + n), 1'b0);
        beat("t4_part", 32'h5A5A5A5A, 32'h000000FF, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        clear          = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'h77777777;
        bus.in_bitmask = 32'hFFFFFFFF;
        bus.in_commit  = 1'b1;
        bus.out_ready  = 1'b1;
        @(posedge clk);
        #1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_commit = 1'b0;
        bus.out_ready = 1'b0;
        sb.delete();
        m_strb = '0;
        @(negedge clk);
        chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
        chk("t4_count", 64'(count), 64'd0);
        beat("t4_new", 32'h0000BE00, 32'h0000FF00, 1'b1, 16'h0044, 1'b0);
        @(negedge clk);
        chk("t4_new_wstrb", 64'(bus.out_wstrb), 64'b0010);
        pop_one("t4_pop");

        // async reset mid-burst
        beat("t5_push", 32'h55555555, 32'hFFFFFFFF, 1'b1, 16'h0055, 1'b0);
        beat("t5_part", 32'h66666666, 32'hFFFF0000, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        #2;
        rstnn = 1'b0;
        #1;
        chk("t5_async_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_async_count", 64'(count), 64'd0);
        sb.delete();
        m_acc  = '0;
        m_strb = '0;
        @(negedge clk);
        rstnn = 1'b1;
        beat("t5_clean", 32'h12345678, 32'h00FF00FF, 1'b1, 16'h0056, 1'b0);
        pop_one("t5_pop");

        // partially masked byte
        beat("t6_bad", 32'h000000A5, 32'h000000F0, 1'b1, 16'h0066, 1'b0);
        @(negedge clk);
        chk("t6_mask_error", 64'(mask_error), 64'(exp_err));
        chk("t6_wstrb", 64'(bus.out_wstrb), 64'b0000);
        pop_one("t6_pop");
        beat("t6_good", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        chk("t6_sticky", 64'(mask_error), 64'(exp_err));
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        m_strb = '0;
        @(negedge clk);
        chk("t6_cleared", 64'(mask_error), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    task automatic pop_one_empty();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("empty_pop_count", 64'(count), 64'd0);
        chk("empty_pop_valid", 64'(bus.out_valid), 64'd0);
    endtask
endmodule
